// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multicycle CPU core: opcodes, branch conditions,
// ALU operation codes, FSM states, flag bit positions and small decode helpers.
package cpu_mc_pkg;

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_RTM = 4'h6;
  localparam logic [3:0] OP_MTR = 4'h7;

  localparam logic [3:0] BR_JMP = 4'h8;
  localparam logic [3:0] BR_BZ  = 4'h4;
  localparam logic [3:0] BR_BNZ = 4'h5;
  localparam logic [3:0] BR_BC  = 4'h6;
  localparam logic [3:0] BR_BNC = 4'h7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  // R-type opcodes (1xxx) carry the ALU code directly. The C-type opcodes
  // 0001..0101 select ADD..XOR, so 4'h1 is add-immediate.
  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    logic [2:0] sel;
    if (op[3]) sel = op[2:0];
    else       sel = op[2:0] - 3'd1;
    return sel;
  endfunction

  // Branch condition evaluation on the stored flags.
  function automatic logic br_taken(input logic [3:0] op2, input logic [1:0] fl);
    logic t;
    case (op2)
      BR_JMP:  t = 1'b1;
      BR_BZ:   t = fl[FLAG_Z];
      BR_BNZ:  t = ~fl[FLAG_Z];
      BR_BC:   t = fl[FLAG_C];
      BR_BNC:  t = ~fl[FLAG_C];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational ALU for the multicycle CPU core. Produces the result plus
// zero and carry/borrow flags packed as {carry, zero}.
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] r,
  output logic [1:0]        flags
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_r;
  logic              w_c;

  assign w_sum = {1'b0, a} + {1'b0, b};

  // Result and carry selection per operation.
  always_comb begin
    w_r = '0;
    w_c = 1'b0;
    case (op)
      ALU_ADD: begin
        w_r = w_sum[DATA_W-1:0];
        w_c = w_sum[DATA_W];
      end
      ALU_SUB: begin
        w_r = a - b;
        w_c = (a < b);
      end
      ALU_AND:  w_r = a & b;
      ALU_OR:   w_r = a | b;
      ALU_XOR:  w_r = a ^ b;
      ALU_SHL: begin
        w_r = {a[DATA_W-2:0], 1'b0};
        w_c = a[DATA_W-1];
      end
      ALU_SHR: begin
        w_r = {1'b0, a[DATA_W-1:1]};
        w_c = a[0];
      end
      default:  w_r = b;
    endcase
  end

  assign r             = w_r;
  assign flags[FLAG_Z] = (w_r == '0);
  assign flags[FLAG_C] = w_c;

endmodule

// File: rtl/cpu_core_mc.sv
// Multicycle CPU core: FETCH/EXEC/MEM_WAIT/HALT FSM, 4-entry register file,
// stored zero/carry flags. Instruction ROM is read combinationally; data RAM
// returns load data one cycle after the address is presented.
// Optional macro CPU_MC_INSTRET_EN adds a 32-bit retired-instruction counter.
module cpu_core_mc
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               halted,
  output logic [IMEM_AW-1:0] pc,
  output logic [1:0]         flags
`ifdef CPU_MC_INSTRET_EN
  ,
  output logic [31:0]        instret
`endif
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IMEM_AW-1:0]  r_pc;
  logic [IMEM_AW-1:0]  w_pc_nxt;
  logic [15:0]         r_ir;
  logic [1:0]          r_flags;
  logic [DATA_W-1:0]   r_rf [4];

  logic [3:0]          w_op;
  logic [7:0]          w_const;
  logic [1:0]          w_rs2;
  logic [1:0]          w_rs1;
  logic [1:0]          w_re;
  logic [3:0]          w_op2;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_alu_r;
  logic [1:0]          w_alu_flags;
  logic                w_rf_we;
  logic [DATA_W-1:0]   w_rf_wdata;
  logic                w_flags_we;
  logic [IMEM_AW-1:0]  w_pc_inc;

  assign w_op     = r_ir[15:12];
  assign w_const  = r_ir[11:4];
  assign w_rs2    = r_ir[5:4];
  assign w_rs1    = r_ir[3:2];
  assign w_re     = r_ir[1:0];
  assign w_op2    = r_ir[3:0];
  assign w_b      = w_op[3] ? r_rf[w_rs2] : DATA_W'(w_const);
  assign w_pc_inc = r_pc + IMEM_AW'(1);

  cpu_mc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a     (r_rf[w_rs1]),
    .b     (w_b),
    .op    (alu_sel(w_op)),
    .r     (w_alu_r),
    .flags (w_alu_flags)
  );

  // Next-state, pc, write-enable and data-memory strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rf_we     = 1'b0;
    w_rf_wdata  = w_alu_r;
    w_flags_we  = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    case (r_state)
      FETCH: w_state_nxt = EXEC;
      EXEC: begin
        if (w_op == OP_BR) begin
          if (r_ir == 16'h0000) begin
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt    = br_taken(w_op2, r_flags) ? w_const[IMEM_AW-1:0] : w_pc_inc;
            w_state_nxt = FETCH;
          end
        end else if (w_op == OP_RTM) begin
          dmem_we     = 1'b1;
          dmem_addr   = w_const[DMEM_AW-1:0];
          dmem_wdata  = r_rf[w_rs1];
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = FETCH;
        end else if (w_op == OP_MTR) begin
          dmem_addr   = w_const[DMEM_AW-1:0];
          w_state_nxt = MEM_WAIT;
        end else begin
          w_rf_we     = 1'b1;
          w_flags_we  = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = FETCH;
        end
      end
      MEM_WAIT: begin
        w_rf_we     = 1'b1;
        w_rf_wdata  = dmem_rdata;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = FETCH;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // Program counter, instruction register and flags; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_flags <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (r_state == FETCH) r_ir <= imem_data;
      if (w_flags_we) r_flags <= w_alu_flags;
    end
  end

  // Register file; operands read the old value when Re matches a source.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else if (w_rf_we) begin
      r_rf[w_re] <= w_rf_wdata;
    end
  end

`ifdef CPU_MC_INSTRET_EN
  logic        w_retire;
  logic [31:0] r_instret;

  // Retirement: leaving EXEC toward FETCH, or completing a load.
  assign w_retire = ((r_state == EXEC) && (w_state_nxt == FETCH)) || (r_state == MEM_WAIT);

  // Retired-instruction counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst)           r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`endif

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign flags     = r_flags;
  assign halted    = (r_state == HALT);

endmodule

// File: tb/tb_cpu_core_mc.sv
// Self-checking bench for cpu_core_mc: an instruction-level reference model
// predicts pc/flags per instruction and pushes expected stores to a scoreboard
// that is drained when the core pulses dmem_we.
module tb_cpu_core_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_rdata;
  logic        halted;
  logic [7:0]  pc;
  logic [1:0]  flags;
`ifdef CPU_MC_INSTRET_EN
  logic [31:0] instret;
`endif

  always #5 clk = ~clk;

  cpu_core_mc dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .pc         (pc),
    .flags      (flags)
`ifdef CPU_MC_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  logic [15:0] imem [256];
  logic [7:0]  dm   [256] = '{default: 8'h00};

  assign imem_data = imem[imem_addr];

  always @(posedge clk) begin
    if (dmem_we) dm[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dm[dmem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_extra = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state.
  logic [7:0]  mpc;
  logic [7:0]  mr  [4];
  logic [7:0]  mdm [256];
  logic        mz, mc;
  int unsigned m_inst;
  logic [15:0] sb [$];

  function automatic logic [15:0] ec(input logic [3:0] op, input logic [7:0] k,
                                     input logic [1:0] rs1, input logic [1:0] re);
    return {op, k, rs1, re};
  endfunction

  function automatic logic [15:0] er(input logic [3:0] op, input logic [1:0] rs2,
                                     input logic [1:0] rs1, input logic [1:0] re);
    return {op, 6'b0, rs2, rs1, re};
  endfunction

  function automatic logic [15:0] eb(input logic [7:0] tgt, input logic [3:0] op2);
    return {4'h0, tgt, op2};
  endfunction

  // Store monitor: every strobe must match the oldest predicted store.
  always @(negedge clk) begin
    if (!rst && dmem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_extra++;
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("store addr", dmem_addr, e[15:8]);
        check("store data", dmem_wdata, e[7:0]);
      end
    end
  end

  task automatic model_reset();
    mpc = 8'h00;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    mz = 1'b0;
    mc = 1'b0;
    m_inst = 0;
    sb.delete();
    n_extra = 0;
  endtask

  task automatic model_step(output int lat, output bit hlt);
    logic [15:0] ir;
    logic [3:0]  op;
    logic [7:0]  k, a, b, r;
    logic [1:0]  rs1, rs2, re;
    logic [2:0]  aop;
    logic [8:0]  s;
    logic        c;
    bit          tk;
    ir  = imem[mpc];
    op  = ir[15:12];
    k   = ir[11:4];
    rs2 = ir[5:4];
    rs1 = ir[3:2];
    re  = ir[1:0];
    lat = 2;
    hlt = 1'b0;
    if (ir == 16'h0000) begin
      hlt = 1'b1;
    end else if (op == 4'h0) begin
      case (ir[3:0])
        4'h8:    tk = 1'b1;
        4'h4:    tk = mz;
        4'h5:    tk = !mz;
        4'h6:    tk = mc;
        4'h7:    tk = !mc;
        default: tk = 1'b0;
      endcase
      mpc = tk ? k : mpc + 8'd1;
      m_inst++;
    end else if (op == 4'h6) begin
      sb.push_back({k, mr[rs1]});
      mdm[k] = mr[rs1];
      mpc = mpc + 8'd1;
      m_inst++;
    end else if (op == 4'h7) begin
      mr[re] = mdm[k];
      lat = 3;
      mpc = mpc + 8'd1;
      m_inst++;
    end else begin
      a   = mr[rs1];
      b   = op[3] ? mr[rs2] : k;
      aop = op[3] ? op[2:0] : op[2:0] - 3'd1;
      c   = 1'b0;
      case (aop)
        3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
        3'd1: begin r = a - b; c = (a < b); end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: begin r = a << 1; c = a[7]; end
        3'd6: begin r = a >> 1; c = a[0]; end
        default: r = b;
      endcase
      mr[re] = r;
      mz = (r == 8'h00);
      mc = c;
      mpc = mpc + 8'd1;
      m_inst++;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check({tag, " rst pc"}, pc, 8'h00);
    check({tag, " rst halted"}, halted, 1'b0);
    check({tag, " rst flags"}, flags, 2'b00);
    check({tag, " rst we"}, dmem_we, 1'b0);
    check({tag, " rst addr"}, dmem_addr, 8'h00);
    check({tag, " rst wdata"}, dmem_wdata, 8'h00);
  endtask

  task automatic run_steps(input int n, input string tag);
    int lat;
    bit hlt;
    for (int i = 0; i < n; i++) begin
      model_step(lat, hlt);
      repeat (lat) @(posedge clk);
      #1;
      check($sformatf("%s pc step%0d", tag, i), pc, mpc);
      check($sformatf("%s flags step%0d", tag, i), flags, {mc, mz});
      check($sformatf("%s halted step%0d", tag, i), halted, hlt);
`ifdef CPU_MC_INSTRET_EN
      check($sformatf("%s instret step%0d", tag, i), instret, m_inst);
`endif
      if (hlt) begin
        for (int j = 0; j < 4; j++) begin
          @(posedge clk);
          #1;
          check($sformatf("%s halt pc hold%0d", tag, j), pc, mpc);
          check($sformatf("%s halt stays%0d", tag, j), halted, 1'b1);
        end
        break;
      end
    end
    check({tag, " pending stores"}, sb.size(), 0);
    check({tag, " stray stores"}, n_extra, 0);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mdm[i] = 8'h00;

    // Program A: ALU ops, stores, load, halt.
    clear_imem();
    imem[0]  = 16'h1054;
    imem[1]  = ec(4'h6, 8'h00, 2'd0, 2'd0);
    imem[2]  = ec(4'h1, 8'hF0, 2'd2, 2'd1);
    imem[3]  = ec(4'h1, 8'h20, 2'd3, 2'd2);
    imem[4]  = er(4'h8, 2'd2, 2'd1, 2'd3);
    imem[5]  = ec(4'h6, 8'h01, 2'd3, 2'd0);
    imem[6]  = er(4'h9, 2'd1, 2'd1, 2'd0);
    imem[7]  = ec(4'h1, 8'h3C, 2'd0, 2'd1);
    imem[8]  = ec(4'h6, 8'h0A, 2'd1, 2'd0);
    imem[9]  = er(4'h9, 2'd0, 2'd0, 2'd0);
    imem[10] = ec(4'h7, 8'h0A, 2'd0, 2'd2);
    imem[11] = ec(4'h6, 8'h0B, 2'd2, 2'd0);
    imem[12] = er(4'hB, 2'd3, 2'd1, 2'd0);
    imem[13] = er(4'hC, 2'd2, 2'd1, 2'd0);
    imem[14] = er(4'hE, 2'd0, 2'd3, 2'd3);
    imem[15] = er(4'hF, 2'd1, 2'd0, 2'd0);
    imem[16] = er(4'hA, 2'd3, 2'd0, 2'd0);
    imem[17] = ec(4'h6, 8'h0C, 2'd0, 2'd0);
    imem[18] = er(4'h8, 2'd0, 2'd0, 2'd0);
    imem[19] = ec(4'h6, 8'h0D, 2'd0, 2'd0);
    imem[20] = ec(4'h2, 8'h11, 2'd0, 2'd1);
    imem[21] = ec(4'h6, 8'h0E, 2'd1, 2'd0);
    imem[22] = er(4'hE, 2'd0, 2'd1, 2'd1);
    imem[23] = ec(4'h6, 8'h0F, 2'd1, 2'd0);
    imem[24] = 16'h0000;
    do_reset("A");
    run_steps(40, "A");
    do_reset("A post-halt");

    // Program B: branches and pc wrap.
    clear_imem();
    imem[8'h00] = eb(8'h10, 4'h8);
    imem[8'h10] = er(4'h9, 2'd0, 2'd0, 2'd0);
    imem[8'h11] = eb(8'h20, 4'h4);
    imem[8'h20] = eb(8'h40, 4'h5);
    imem[8'h21] = eb(8'h55, 4'h3);
    imem[8'h22] = eb(8'h30, 4'h6);
    imem[8'h23] = ec(4'h1, 8'hFF, 2'd0, 2'd1);
    imem[8'h24] = er(4'hD, 2'd0, 2'd1, 2'd1);
    imem[8'h25] = eb(8'h10, 4'h7);
    imem[8'h26] = eb(8'hFF, 4'h6);
    imem[8'hFF] = 16'h0001;
    do_reset("B");
    run_steps(11, "B");
    check("B pc wrap", pc, 8'h00);

    // Program C: reset while a load is waiting on the RAM.
    clear_imem();
    imem[0] = ec(4'h1, 8'h3C, 2'd0, 2'd1);
    imem[1] = ec(4'h6, 8'h0A, 2'd1, 2'd0);
    imem[2] = ec(4'h7, 8'h0A, 2'd0, 2'd2);
    do_reset("C");
    run_steps(2, "C");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("C memwait rst pc", pc, 8'h00);
    check("C memwait rst halted", halted, 1'b0);
    check("C memwait rst flags", flags, 2'b00);
`ifdef CPU_MC_INSTRET_EN
    check("C memwait rst instret", instret, 32'd0);
`endif
    imem[0] = ec(4'h6, 8'h0B, 2'd2, 2'd0);
    imem[1] = 16'h0000;
    imem[2] = 16'h0000;
    run_steps(3, "C2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
